id_bypass_stage: RTL
====================

Name: id_bypass_stage

Overview:
Parametrised operand-resolution and ID/EX pipeline-register stage for the 32-bit pipeline, succeeding the combinational decode-bypass logic.
- Resolves NUM_SRC source operands against NUM_FWD prioritised forwarding channels.
- Raises a load-use interlock when a matching producer's data is not yet available.
- Registers resolved operands plus opaque decoded control into EX behind a valid/ready handshake, with flush and a saturating stall counter.

Parameters:
DATA_W, 32, operand width
REG_AW, 5, register-index width
NUM_SRC, 2, source operands per instruction
NUM_FWD, 2, forwarding channels; index 0 = youngest = highest priority (EX before MEM)
CTRL_W, 32, width of passthrough decoded-control bundle
ZERO_REG, 1, 1 = register 0 hardwired zero: never forwarded, never interlocks
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_src  in  NUM_SRC*REG_AW  source register indices, operand k at [k*REG_AW +: REG_AW]
in_rfdata  in  NUM_SRC*DATA_W  register-file read data per operand
in_ctrl  in  CTRL_W  decoded control, passed through untouched
fwd_valid  in  NUM_FWD  channel j writes a register
fwd_data_ok  in  NUM_FWD  channel j result available (0 = load in flight)
fwd_dst  in  NUM_FWD*REG_AW  channel j destination index
fwd_data  in  NUM_FWD*DATA_W  channel j result
flush  in  1  kill register contents and input this cycle
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX consumes out this cycle
out_opnd  out  NUM_SRC*DATA_W  resolved operands
out_ctrl  out  CTRL_W  registered control
pause_req  out  1  interlock request to PC/IF (`ID_PAUSE_REQUEST when asserted)
stall_cnt  out  CNT_W  saturating count of interlock cycles

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_opnd=0, out_ctrl=0, stall_cnt=0. Combinational outputs follow inputs during reset; rst takes priority over flush.
- Operand k resolution (combinational):
  - Scan j=0..NUM_FWD-1. The first j with fwd_valid[j] and fwd_dst[j]==src_k wins.
  - If ZERO_REG=1 and src_k=0, skip the scan: operand = in_rfdata_k.
  - Winner with fwd_data_ok=1: operand = fwd_data[j]. Winner with data_ok=0: hazard_k=1; lower-priority channels are NOT consulted.
  - No winner: operand = in_rfdata_k.
- hazard = OR of hazard_k; pause_req = in_valid & hazard.
- in_ready = !hazard & !flush & (!out_valid | out_ready).
- Register update each posedge, rst=0, in priority order:
  - flush: out_valid<=0; out_opnd and out_ctrl hold.
  - in_valid & in_ready: out_valid<=1; out_opnd and out_ctrl load the resolved values.
  - out_ready: out_valid<=0 (bubble inserted on interlock).
  - else: hold everything, i.e. downstream stall.
- Latency: accepted instruction appears at out_valid exactly 1 cycle later. Throughput 1/cycle with no hazard and out_ready=1.
- While out_valid=1 and out_ready=0, out_opnd/out_ctrl stay stable. Operands are captured at accept, so producers retiring during the stall are irrelevant.
- stall_cnt increments when in_valid & hazard & !flush, and saturates at all-ones with no wrap.
- flush together with in_valid: the input is not accepted, and pause_req still reflects hazard.
- Multiple operands matching different channels are resolved independently. The same channel may feed several operands.

Decomposition:
- Shared constants in defines.v: `Enable/`Disable, `ID_PAUSE_REQUEST/`NO_PAUSE_REQUEST, `ZeroReg index.
- No new typedefs; ctrl is an opaque vector.
- One sub-module, fwd_select: single-operand priority scan over NUM_FWD channels, outputs operand and hazard. Instantiated NUM_SRC times via generate.
- Top holds the handshake, register and counter.

Test Plan:
1. Reset, then in_valid=1, src0=3, rfdata0=0x11, no fwd_valid → next cycle out_valid=1, out_opnd0=0x11, pause_req=0 throughout.
2. src0=5, fwd0 and fwd1 both valid with dst=5, data 0xAAAA/0xBBBB, data_ok=1 → out_opnd0=0xAAAA (channel 0 priority). With fwd_valid[0]=0 → 0xBBBB.
3. Load-use: src1=7, fwd0 dst=7 data_ok=0 for 2 cycles, then 1 with data 0x1234 → pause_req=1, in_ready=0 for 2 cycles, 2 bubbles (out_valid=0), stall_cnt=2, then out_opnd1=0x1234. fwd1 matching with data_ok=1 during the hazard must not override.
4. ZERO_REG=1, src0=0, fwd0 dst=0 data_ok=0, rfdata0=0 → no hazard, out_opnd0=0.
5. out_ready=0 for 3 cycles with out_valid=1 → out_opnd/out_ctrl unchanged, in_ready=0. Assert flush mid-stall → out_valid=0 next cycle, input not accepted during the flush cycle.
6. Hold hazard for 2^CNT_W+5 cycles → stall_cnt sticks at all-ones. Assert rst mid-interlock → all registered outputs 0 next cycle.

Source files
------------

// File: rtl/id_bypass_stage_pkg.sv
// Shared constants for the ID operand-bypass stage: enable levels, pause-request
// encoding and the hardwired-zero register index.
package id_bypass_stage_pkg;

  localparam logic ENABLE           = 1'b1;
  localparam logic DISABLE          = 1'b0;
  localparam logic ID_PAUSE_REQUEST = 1'b1;
  localparam logic NO_PAUSE_REQUEST = 1'b0;
  localparam int   ZERO_REG_IDX     = 0;

endpackage : id_bypass_stage_pkg

// File: rtl/id_bypass_stage_fwd_select.sv
// Single-operand priority scan over the forwarding channels: channel 0 is the
// youngest producer and wins; a winning producer without data raises hazard.
module id_bypass_stage_fwd_select
  import id_bypass_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0]         src,
  input  logic [DATA_W-1:0]         rfdata,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         opnd,
  output logic                      hazard
);

  logic found;
  logic is_zero_reg;

  assign is_zero_reg = (ZERO_REG != 0) && (src == REG_AW'(ZERO_REG_IDX));

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    opnd   = rfdata;
    hazard = DISABLE;
    found  = DISABLE;
    if (!is_zero_reg) begin
      for (int j = 0; j < NUM_FWD; j++) begin
        // Once the youngest match is found, older channels are ignored even if
        // they hold ready data: their value would be stale.
        if (!found && fwd_valid[j] && (fwd_dst[j*REG_AW +: REG_AW] == src)) begin
          found = ENABLE;
          if (fwd_data_ok[j]) opnd   = fwd_data[j*DATA_W +: DATA_W];
          else                hazard = ENABLE;
        end
      end
    end
  end

endmodule : id_bypass_stage_fwd_select

// File: rtl/id_bypass_stage.sv
// Operand resolution plus ID/EX pipeline register: forwards operands, interlocks
// on load-use, and hands resolved operands and control to EX via valid/ready.
module id_bypass_stage
  import id_bypass_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int CTRL_W   = 32,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*REG_AW-1:0] in_src,
  input  logic [NUM_SRC*DATA_W-1:0] in_rfdata,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SRC*DATA_W-1:0] out_opnd,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic                      pause_req,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_SRC*DATA_W-1:0] opnd_res;
  logic [NUM_SRC-1:0]        hazard_vec;
  logic                      hazard;
  logic                      accept;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    id_bypass_stage_fwd_select #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD),
      .ZERO_REG(ZERO_REG)
    ) u_fwd_select (
      .src        (in_src[k*REG_AW +: REG_AW]),
      .rfdata     (in_rfdata[k*DATA_W +: DATA_W]),
      .fwd_valid  (fwd_valid),
      .fwd_data_ok(fwd_data_ok),
      .fwd_dst    (fwd_dst),
      .fwd_data   (fwd_data),
      .opnd       (opnd_res[k*DATA_W +: DATA_W]),
      .hazard     (hazard_vec[k])
    );
  end

  assign hazard    = |hazard_vec;
  assign pause_req = (in_valid && hazard) ? ID_PAUSE_REQUEST : NO_PAUSE_REQUEST;
  assign in_ready  = !hazard && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= DISABLE;
      out_opnd  <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= DISABLE;
    end else if (accept) begin
      out_valid <= ENABLE;
      out_opnd  <= opnd_res;
      out_ctrl  <= in_ctrl;
    end else if (out_ready) begin
      // Consumed with nothing new accepted: this is where interlock bubbles enter EX.
      out_valid <= DISABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule : id_bypass_stage
